// File: rtl/ps2_lane_scheduler.sv
// PS/2 scan-code parser feeding a 4-lane held-state map and a timestamped press/release event FIFO.
// Optional `ARROW_LANES_EN also maps E0-prefixed arrow keys onto lanes 0..3.
module ps2_lane_scheduler #(
  parameter logic [7:0] KEY0       = 8'h23,
  parameter logic [7:0] KEY1       = 8'h2B,
  parameter logic [7:0] KEY2       = 8'h3B,
  parameter logic [7:0] KEY3       = 8'h42,
  parameter int         FIFO_DEPTH = 4,
  parameter int         TS_W       = 16,
  parameter int         TIMEOUT    = 50000
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic [3:0]      lane_state,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [1:0]      evt_lane,
  output logic            evt_press,
  output logic [TS_W-1:0] evt_time,
  output logic            overflow,
  input  logic            clr_overflow
);

  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int TOW = $clog2(TIMEOUT + 1);
  localparam int EW  = TS_W + 3;
  localparam logic [7:0] KEYS [4] = '{KEY0, KEY1, KEY2, KEY3};

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t          state_reg;
  logic [TOW-1:0]  to_cnt_reg;
  logic [TS_W-1:0] ts_reg;

  logic [3:0] std_hit;
  logic [3:0] ext_hit;
  logic [3:0] hit;
  logic [1:0] lane_sel;
  logic       lane_hit;
  logic       is_break;
  logic       is_ext;
  logic       is_resolve;
  logic       push;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      assign std_hit[gi] = (byte_data == KEYS[gi]);
    end
  endgenerate

`ifdef ARROW_LANES_EN
  assign ext_hit = {byte_data == 8'h74, byte_data == 8'h75,
                    byte_data == 8'h72, byte_data == 8'h6B};
`else
  assign ext_hit = 4'b0000;
`endif

  assign is_break = (state_reg == BRK) || (state_reg == EXT_BRK);
  assign is_ext   = (state_reg == EXT) || (state_reg == EXT_BRK);
  assign hit      = is_ext ? ext_hit : std_hit;

  // Break states resolve on any byte; IDLE/EXT resolve on anything that is not a prefix.
  assign is_resolve = byte_valid &&
                      (is_break || ((byte_data != 8'hE0) && (byte_data != 8'hF0)));

  always_comb begin
    lane_sel = 2'd0;
    lane_hit = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (hit[i]) begin
        lane_sel = 2'(i);
        lane_hit = 1'b1;
      end
    end
  end

  // Typematic repeats and breaks of unheld lanes produce no event.
  assign push = is_resolve && lane_hit && (is_break ? lane_state[lane_sel] : !lane_state[lane_sel]);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      to_cnt_reg <= '0;
    end else if (byte_valid) begin
      to_cnt_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (byte_data == 8'hE0)      state_reg <= EXT;
          else if (byte_data == 8'hF0) state_reg <= BRK;
          else                         state_reg <= IDLE;
        end
        EXT: begin
          if (byte_data == 8'hF0)      state_reg <= EXT_BRK;
          else if (byte_data == 8'hE0) state_reg <= EXT;
          else                         state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end else if (state_reg != IDLE) begin
      if (to_cnt_reg == TOW'(TIMEOUT - 1)) begin
        state_reg  <= IDLE;
        to_cnt_reg <= '0;
      end else begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      ts_reg     <= '0;
      lane_state <= 4'b0000;
    end else begin
      ts_reg <= ts_reg + 1'b1;
      if (push) lane_state[lane_sel] <= !is_break;
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          pop;
  logic          full;
  logic          accept;
  logic [CW-1:0] vis_count;
  logic [PW-1:0] head_idx;

  assign pop       = evt_valid && evt_ready;
  assign full      = (count_reg == CW'(FIFO_DEPTH));
  assign accept    = push && (!full || pop);
  // Entries written at this edge stay hidden for one more cycle, so only older ones can reach the head.
  assign vis_count = count_reg - CW'(pop);
  assign head_idx  = rd_ptr_reg + PW'(pop);

  always_ff @(posedge clk_in) begin
    if (accept) mem[wr_ptr_reg] <= {lane_sel, !is_break, ts_reg};
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      evt_valid  <= 1'b0;
      evt_lane   <= 2'd0;
      evt_press  <= 1'b0;
      evt_time   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(accept) - CW'(pop);
      evt_valid <= (vis_count != '0);
      if (vis_count != '0) {evt_lane, evt_press, evt_time} <= mem[head_idx];
      if (push && !accept)   overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_lane_scheduler.sv
// Randomized + directed bench for ps2_lane_scheduler with a queue-based event reference model.
module tb_ps2_lane_scheduler;
  localparam int TS_W    = 8;
  localparam int TIMEOUT = 100;
  localparam int DEPTH   = 4;

  logic            clk_in = 1'b0;
  logic            rst = 1'b0;
  logic            byte_valid = 1'b0;
  logic [7:0]      byte_data = 8'h00;
  logic [3:0]      lane_state;
  logic            evt_valid;
  logic            evt_ready = 1'b1;
  logic [1:0]      evt_lane;
  logic            evt_press;
  logic [TS_W-1:0] evt_time;
  logic            overflow;
  logic            clr_overflow = 1'b0;

  ps2_lane_scheduler #(.FIFO_DEPTH(DEPTH), .TS_W(TS_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk_in), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .lane_state(lane_state), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_lane(evt_lane), .evt_press(evt_press), .evt_time(evt_time),
    .overflow(overflow), .clr_overflow(clr_overflow));

  always #5 clk_in = ~clk_in;

  typedef struct {int lane; int press; int t;} ev_t;
  ev_t sb[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk_in or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: prefix flags, held lanes, occupancy while the consumer is stalled.
  bit       m_ext = 0, m_brk = 0, m_ovf = 0, m_set = 0, stall = 0;
  bit [3:0] m_held = 0;
  int       occ = 0, tick_n = 0, m_last = 0;

  function automatic int key_lane(input bit ext, input logic [7:0] b);
    if (!ext) begin
      case (b)
        8'h23: return 0;
        8'h2B: return 1;
        8'h3B: return 2;
        8'h42: return 3;
        default: return -1;
      endcase
    end
`ifdef ARROW_LANES_EN
    case (b)
      8'h6B: return 0;
      8'h72: return 1;
      8'h75: return 2;
      8'h74: return 3;
      default: return -1;
    endcase
`else
    return -1;
`endif
  endfunction

  task automatic resolve(input bit make, input logic [7:0] b, input int t);
    int ln;
    ln = key_lane(m_ext, b);
    if (ln >= 0 && m_held[ln] != make) begin
      m_held[ln] = make;
      if (stall && occ == DEPTH) m_set = 1;
      else begin
        sb.push_back('{ln, int'(make), t});
        if (stall) occ++;
      end
    end
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input int t);
    if ((m_ext || m_brk) && (tick_n - m_last - 1 >= TIMEOUT)) begin
      m_ext = 0;
      m_brk = 0;
    end
    m_last = tick_n;
    if (m_brk)            resolve(0, b, t);
    else if (b == 8'hE0)  m_ext = 1;
    else if (b == 8'hF0)  m_brk = 1;
    else                  resolve(1, b, t);
  endtask

  // One clock cycle: drive inputs, update the model, then check state after the edge.
  task automatic tick(input bit v, input logic [7:0] b, input bit clr);
    byte_valid   = v;
    byte_data    = b;
    clr_overflow = clr;
    m_set        = 0;
    if (v) model_byte(b, cyc % (1 << TS_W));
    if (m_set)    m_ovf = 1;
    else if (clr) m_ovf = 0;
    @(posedge clk_in);
    #1;
    tick_n++;
    byte_valid   = 1'b0;
    clr_overflow = 1'b0;
    chk("lane_state", int'(lane_state), int'(m_held));
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic send(input logic [7:0] b);
    tick(1, b, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 8'h00, 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      idle(1);
      k++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d events left expected 0", sb.size());
    end
    idle(2);
    chk("idle_valid", int'(evt_valid), 0);
  endtask

  // Monitor: pops the scoreboard on each handshake and checks head stability while stalled.
  initial begin
    bit prev_hold;
    int prev_data;
    ev_t e;
    prev_hold = 0;
    prev_data = 0;
    forever begin
      @(negedge clk_in);
      if (rst) begin
        if (prev_hold) begin
          chk("hold_valid", int'(evt_valid), 1);
          chk("hold_data", int'({evt_lane, evt_press, evt_time}), prev_data);
        end
        if (evt_valid && evt_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got lane %0d press %0d expected none", evt_lane, evt_press);
          end else begin
            e = sb.pop_front();
            chk("evt_lane", int'(evt_lane), e.lane);
            chk("evt_press", int'(evt_press), e.press);
            chk("evt_time", int'(evt_time), e.t);
          end
        end
        prev_hold = evt_valid && !evt_ready;
        prev_data = int'({evt_lane, evt_press, evt_time});
      end else begin
        prev_hold = 0;
      end
    end
  end

  initial begin
    logic [7:0] pool [12];
    pool = '{8'h23, 8'h2B, 8'h3B, 8'h42, 8'hE0, 8'hF0, 8'hAA, 8'h75, 8'h6B, 8'h72, 8'h74, 8'hFA};

    #3;
    chk("rst_lane_state", int'(lane_state), 0);
    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_evt_fields", int'({evt_lane, evt_press, evt_time}), 0);
    chk("rst_overflow", int'(overflow), 0);
    #9 rst = 1'b1;
    @(posedge clk_in);
    #1;

    // Basic press / release
    send(8'h23); send(8'hF0); send(8'h23);
    drain();

    // Typematic repeats collapse to one press
    send(8'h2B); send(8'h2B); send(8'h2B); send(8'hF0); send(8'h2B);
    drain();

    // Stalled consumer: 4 queued, 5th dropped, set beats clear, then clear
    evt_ready = 1'b0; stall = 1; occ = 0;
    send(8'h23); send(8'h2B); send(8'h3B); send(8'h42); send(8'hF0); send(8'h23);
    idle(2);
    chk("stall_valid", int'(evt_valid), 1);
    send(8'hF0);
    tick(1, 8'h2B, 1);
    tick(0, 8'h00, 1);
    evt_ready = 1'b1; stall = 0;
    drain();
    send(8'hF0); send(8'h3B); send(8'hF0); send(8'h42);
    drain();

    // Prefix timeout: abandoned after TIMEOUT idle cycles, kept before that
    send(8'hF0); idle(TIMEOUT); send(8'h3B);
    send(8'hF0); idle(10); send(8'h3B);
    drain();

    // Extended arrow sequences
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    drain();

    // Randomized byte stream
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0) idle(1);
      else send(pool[$urandom_range(11)]);
    end
    drain();

    // Asynchronous reset mid-sequence with events queued
    evt_ready = 1'b0; stall = 1; occ = 0;
    for (int l = 0; l < 4; l++) if (m_held[l]) begin send(8'hF0); send(pool[l]); end
    send(8'h23); send(8'h2B); send(8'hE0);
    idle(2);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_evt_valid", int'(evt_valid), 0);
    chk("rstmid_lane_state", int'(lane_state), 0);
    chk("rstmid_overflow", int'(overflow), 0);
    sb.delete();
    m_ext = 0; m_brk = 0; m_held = 0; m_ovf = 0; stall = 0; occ = 0;
    evt_ready = 1'b1;
    #3 rst = 1'b1;
    @(posedge clk_in);
    #1;
    send(8'h42);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
